// File: rtl/lock_reset_sequencer.sv
// Purpose: qualifies a synchronised PLL lock, then releases NUM_OUT active-low resets in staggered order.
// Latency: SYNC_STAGES+1 edges from locked to the first qualify count; rstn_out[k] follows at +LOCK_QUAL-1+k*STAGGER.
// Backpressure: none; lock loss or sw_rst reasserts every output on the next edge, and all outputs are registered.
module lock_reset_sequencer #(
    parameter int NUM_OUT     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_QUAL   = 1024,
    parameter int STAGGER     = 16,
    parameter int CNT_W       = 8
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_locked,
    input  logic               i_sw_rst,
    input  logic               i_clr_lost,
    output logic [NUM_OUT-1:0] o_rstn_out,
    output logic               o_ready,
    output logic               o_lock_lost,
    output logic [CNT_W-1:0]   o_loss_count
);

    localparam int QW = $clog2(LOCK_QUAL + 1);
    localparam int SW = $clog2(STAGGER + 1);
    localparam logic [QW-1:0]    QUAL_MAX = QW'(LOCK_QUAL);
    localparam logic [SW-1:0]    STAG_MAX = SW'(STAGGER);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        QUALIFY   = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_locked_s;

    state_t               r_state, w_state_nxt;
    logic [NUM_OUT-1:0]   r_rstn_out, w_rstn_nxt, w_rstn_shift;
    logic                 r_ready, w_ready_nxt;
    logic                 r_lock_lost, w_lost_nxt;
    logic [CNT_W-1:0]     r_loss_count, w_cnt_nxt;
    logic [QW-1:0]        r_qual_cnt, w_qual_nxt, w_qual_inc;
    logic [SW-1:0]        r_stag_cnt, w_stag_nxt, w_stag_inc;
    logic                 w_loss_evt;
    logic                 w_abort;

    // Synchroniser chain for the asynchronous lock input; only its last stage is used.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_locked};
        end
    end

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    // Next-state and output decode; an abort overrides everything computed in the case.
    always_comb begin
        w_state_nxt  = r_state;
        w_rstn_nxt   = r_rstn_out;
        w_ready_nxt  = r_ready;
        w_qual_nxt   = r_qual_cnt;
        w_stag_nxt   = r_stag_cnt;
        w_loss_evt   = 1'b0;
        w_abort      = 1'b0;
        // WAIT_LOCK seeing lock counts as the first qualified cycle.
        w_qual_inc   = (r_state == QUALIFY) ? r_qual_cnt + 1'b1 : QW'(1);
        w_stag_inc   = r_stag_cnt + 1'b1;
        // Ascending thermometer: the next bit above those already released.
        w_rstn_shift = (r_rstn_out << 1) | NUM_OUT'(1);

        case (r_state)
            WAIT_LOCK, QUALIFY: begin
                if (r_state == QUALIFY && i_sw_rst) begin
                    w_abort = 1'b1;
                end else if (!w_locked_s) begin
                    // Losing lock before any release is not a loss event.
                    w_state_nxt = WAIT_LOCK;
                    w_qual_nxt  = '0;
                end else if (w_qual_inc == QUAL_MAX) begin
                    w_rstn_nxt = NUM_OUT'(1);
                    w_qual_nxt = '0;
                    w_stag_nxt = '0;
                    if (NUM_OUT == 1) begin
                        w_ready_nxt = 1'b1;
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = RELEASE;
                    end
                end else begin
                    w_qual_nxt  = w_qual_inc;
                    w_state_nxt = QUALIFY;
                end
            end
            RELEASE: begin
                if (!w_locked_s) begin
                    w_loss_evt = 1'b1;
                    w_abort    = 1'b1;
                end else if (i_sw_rst) begin
                    w_abort = 1'b1;
                end else if (w_stag_inc == STAG_MAX) begin
                    w_rstn_nxt = w_rstn_shift;
                    w_stag_nxt = '0;
                    if (w_rstn_shift[NUM_OUT-1]) begin
                        w_ready_nxt = 1'b1;
                        w_state_nxt = RUN;
                    end
                end else begin
                    w_stag_nxt = w_stag_inc;
                end
            end
            RUN: begin
                if (!w_locked_s) begin
                    w_loss_evt = 1'b1;
                    w_abort    = 1'b1;
                end else if (i_sw_rst) begin
                    w_abort = 1'b1;
                end
            end
            default: w_abort = 1'b1;
        endcase

        if (w_abort) begin
            w_state_nxt = WAIT_LOCK;
            w_rstn_nxt  = '0;
            w_ready_nxt = 1'b0;
            w_qual_nxt  = '0;
            w_stag_nxt  = '0;
        end

        // A loss on the same edge as a clear leaves the flag set.
        w_lost_nxt = w_loss_evt ? 1'b1 : (i_clr_lost ? 1'b0 : r_lock_lost);
        w_cnt_nxt  = (w_loss_evt && (r_loss_count != CNT_MAX)) ? r_loss_count + 1'b1 : r_loss_count;
    end

    // State, counters and all outputs registered together.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state      <= WAIT_LOCK;
            r_rstn_out   <= '0;
            r_ready      <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_loss_count <= '0;
            r_qual_cnt   <= '0;
            r_stag_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rstn_out   <= w_rstn_nxt;
            r_ready      <= w_ready_nxt;
            r_lock_lost  <= w_lost_nxt;
            r_loss_count <= w_cnt_nxt;
            r_qual_cnt   <= w_qual_nxt;
            r_stag_cnt   <= w_stag_nxt;
        end
    end

    assign o_rstn_out   = r_rstn_out;
    assign o_ready      = r_ready;
    assign o_lock_lost  = r_lock_lost;
    assign o_loss_count = r_loss_count;

endmodule
